// File: rtl/gpio_mmio_ctrl.sv
// gpio_mmio_ctrl: memory-mapped GPIO with direction, set/clear aliases, synchronised inputs and W1C edge interrupts.
// Define GPIO_DEBOUNCE_EN to insert a per-pin debounce filter between the synchroniser and DATA_IN.
module gpio_mmio_ctrl #(
    parameter int DATA_WIDTH      = 32,
    parameter int GPIO_WIDTH      = 8,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] Address,
    input  logic [DATA_WIDTH-1:0] WriteData,
    input  logic                  MemWrite,
    input  logic                  Select,
    output logic [DATA_WIDTH-1:0] ReadData,
    input  logic [GPIO_WIDTH-1:0] gpio_port_in,
    output logic [GPIO_WIDTH-1:0] gpio_port_out,
    output logic [GPIO_WIDTH-1:0] gpio_dir,
    output logic                  irq
);
    localparam logic [2:0] A_DOUT = 3'd0, A_DIN = 3'd1, A_DIR = 3'd2, A_IEN = 3'd3;
    localparam logic [2:0] A_STAT = 3'd4, A_EDGE = 3'd5, A_SET = 3'd6, A_CLR = 3'd7;
`ifdef GPIO_DEBOUNCE_EN
    localparam int ARM_CYCLES = SYNC_STAGES + DEBOUNCE_CYCLES + 1;
`else
    localparam int ARM_CYCLES = SYNC_STAGES + 1;
    localparam int unused_debounce = DEBOUNCE_CYCLES;
`endif
    localparam int AW = $clog2(ARM_CYCLES + 1);

    logic [GPIO_WIDTH-1:0] data_out_q, data_out_d, dir_q, dir_d, irq_en_q, irq_en_d;
    logic [GPIO_WIDTH-1:0] status_q, status_d, edge_sel_q, edge_sel_d;
    logic [GPIO_WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [GPIO_WIDTH-1:0] data_in, prev_in_q, event_w, wdata, rdata;
    logic [AW-1:0]         arm_q;
    logic [2:0]            sel;
    logic                  we, armed;
    logic                  unused_bits;

    assign we          = Select & MemWrite;
    assign sel         = Address[4:2];
    assign wdata       = WriteData[GPIO_WIDTH-1:0];
    assign unused_bits = ^{Address[DATA_WIDTH-1:5], Address[1:0], WriteData};
    // Covers the full pin-to-DATA_IN latency so pins already high at reset raise no event
    assign armed       = arm_q == AW'(ARM_CYCLES);
    assign event_w     = (edge_sel_q & data_in & ~prev_in_q) | (~edge_sel_q & ~data_in & prev_in_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
        end else begin
            sync_q[0] <= gpio_port_in;
            for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
        end
    end

`ifdef GPIO_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    logic [CW-1:0]         cnt_q [GPIO_WIDTH];
    logic [GPIO_WIDTH-1:0] data_in_q;
    always_ff @(posedge clk) begin
        for (int i = 0; i < GPIO_WIDTH; i++) begin
            if (reset) begin
                cnt_q[i]     <= '0;
                data_in_q[i] <= 1'b0;
            end else if (sync_q[SYNC_STAGES-1][i] == data_in_q[i]) begin
                cnt_q[i] <= '0;
            end else if (cnt_q[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
                cnt_q[i]     <= '0;
                data_in_q[i] <= sync_q[SYNC_STAGES-1][i];
            end else begin
                cnt_q[i] <= cnt_q[i] + CW'(1);
            end
        end
    end
    assign data_in = data_in_q;
`else
    assign data_in = sync_q[SYNC_STAGES-1];
`endif

    always_comb begin
        data_out_d = !we           ? data_out_q :
                     sel == A_DOUT ? wdata :
                     sel == A_SET  ? data_out_q | wdata :
                     sel == A_CLR  ? data_out_q & ~wdata : data_out_q;
        dir_d      = (we && sel == A_DIR)  ? wdata : dir_q;
        irq_en_d   = (we && sel == A_IEN)  ? wdata : irq_en_q;
        edge_sel_d = (we && sel == A_EDGE) ? wdata : edge_sel_q;
        // A new event outranks a same-cycle write-1-to-clear
        status_d   = (status_q & ~((we && sel == A_STAT) ? wdata : '0)) | (armed ? event_w : '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_out_q <= '0;
            dir_q      <= '0;
            irq_en_q   <= '0;
            status_q   <= '0;
            edge_sel_q <= '0;
            prev_in_q  <= '0;
            arm_q      <= '0;
        end else begin
            data_out_q <= data_out_d;
            dir_q      <= dir_d;
            irq_en_q   <= irq_en_d;
            status_q   <= status_d;
            edge_sel_q <= edge_sel_d;
            prev_in_q  <= data_in;
            arm_q      <= armed ? arm_q : arm_q + AW'(1);
        end
    end

    always_comb begin
        case (sel)
            A_DOUT:  rdata = data_out_q;
            A_DIN:   rdata = data_in;
            A_DIR:   rdata = dir_q;
            A_IEN:   rdata = irq_en_q;
            A_STAT:  rdata = status_q;
            A_EDGE:  rdata = edge_sel_q;
            default: rdata = '0;
        endcase
    end

    assign ReadData      = Select ? DATA_WIDTH'(rdata) : '0;
    assign gpio_port_out = data_out_q & dir_q;
    assign gpio_dir      = dir_q;
    assign irq           = |(status_q & irq_en_q);
endmodule

// File: tb/tb_gpio_mmio_ctrl.sv
// tb_gpio_mmio_ctrl: scoreboard bench for gpio_mmio_ctrl; expectations are queued with stimulus and checked on drain.
module tb_gpio_mmio_ctrl;
    localparam int S = 2;
    localparam int D = 4;
`ifdef GPIO_DEBOUNCE_EN
    localparam int LAT = S + D;
`else
    localparam int LAT = S;
`endif
    localparam int SRC_RD = 0, SRC_OUT = 1, SRC_DIR = 2, SRC_IRQ = 3, SRC_NOSEL = 4;

    typedef struct {
        string       tag;
        int          src;
        logic [31:0] addr;
        logic [31:0] exp;
    } item_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] Address, WriteData, ReadData;
    logic        MemWrite, Select, irq;
    logic [7:0]  gpio_port_in, gpio_port_out, gpio_dir;
    item_t       sb[$];
    int          n_checks = 0;
    int          n_fail = 0;

    gpio_mmio_ctrl #(.DATA_WIDTH(32), .GPIO_WIDTH(8), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(D)) dut (
        .clk(clk), .reset(reset), .Address(Address), .WriteData(WriteData),
        .MemWrite(MemWrite), .Select(Select), .ReadData(ReadData),
        .gpio_port_in(gpio_port_in), .gpio_port_out(gpio_port_out),
        .gpio_dir(gpio_dir), .irq(irq)
    );

    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic push(input string tag, input int src, input logic [31:0] addr, input logic [31:0] exp);
        item_t it;
        it.tag = tag; it.src = src; it.addr = addr; it.exp = exp;
        sb.push_back(it);
    endtask

    task automatic drain();
        item_t       it;
        logic [31:0] act;
        while (sb.size() > 0) begin
            it = sb.pop_front();
            act = '0;
            case (it.src)
                SRC_RD, SRC_NOSEL: begin
                    Address = it.addr; MemWrite = 1'b0; Select = (it.src == SRC_RD);
                    #1 act = ReadData;
                    Select = 1'b0;
                end
                SRC_OUT: act = 32'(gpio_port_out);
                SRC_DIR: act = 32'(gpio_dir);
                default: act = 32'(irq);
            endcase
            check(it.tag, act, it.exp);
        end
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        Address = addr; WriteData = data; MemWrite = 1'b1; Select = 1'b1;
        @(negedge clk);
        MemWrite = 1'b0; Select = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; Address = '0; WriteData = '0; MemWrite = 1'b0; Select = 1'b0; gpio_port_in = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        push("rst_out", SRC_OUT, 0, 0);
        push("rst_dir", SRC_DIR, 0, 0);
        push("rst_irq", SRC_IRQ, 0, 0);
        push("rst_dout", SRC_RD, 32'h00, 0);
        push("rst_stat", SRC_RD, 32'h10, 0);
        drain();
        repeat (LAT + 3) @(negedge clk);
        // Output register, set/clear aliases and read rules
        wr(32'h08, 32'hFF);
        wr(32'h00, 32'hA5);
        push("out_a5", SRC_OUT, 0, 32'hA5);
        drain();
        wr(32'h18, 32'h0A);
        push("out_set", SRC_OUT, 0, 32'hAF);
        drain();
        wr(32'h1C, 32'h05);
        push("out_clr", SRC_OUT, 0, 32'hAA);
        push("rd_dout", SRC_RD, 32'h00, 32'hAA);
        drain();
        wr(32'h04, 32'hFF);
        push("din_ro", SRC_RD, 32'h04, 0);
        push("rd_set0", SRC_RD, 32'h18, 0);
        push("rd_clr0", SRC_RD, 32'h1C, 0);
        push("nosel0", SRC_NOSEL, 32'h00, 0);
        drain();
        // Direction masking and upper-bit handling
        wr(32'h08, 32'hFFFF_FF0F);
        wr(32'h00, 32'hFF);
        push("out_masked", SRC_OUT, 0, 32'h0F);
        push("dir_out", SRC_DIR, 0, 32'h0F);
        push("rd_dout_ff", SRC_RD, 32'h00, 32'hFF);
        push("rd_dir_0f", SRC_RD, 32'h08, 32'h0F);
        drain();
        // Rising edge on pin0 with interrupt enabled
        wr(32'h14, 32'h01);
        wr(32'h0C, 32'h01);
        gpio_port_in = 8'h01;
        repeat (LAT) @(negedge clk);
        push("irq_early", SRC_IRQ, 0, 0);
        push("stat_early", SRC_RD, 32'h10, 0);
        drain();
        @(negedge clk);
        push("irq_set", SRC_IRQ, 0, 1);
        push("stat_set", SRC_RD, 32'h10, 32'h01);
        push("din_pin0", SRC_RD, 32'h04, 32'h01);
        drain();
        wr(32'h10, 32'h01);
        push("w1c_stat", SRC_RD, 32'h10, 0);
        push("w1c_irq", SRC_IRQ, 0, 0);
        drain();
        gpio_port_in = 8'h00;
        repeat (LAT + 3) @(negedge clk);
        push("fall0_ignored", SRC_RD, 32'h10, 0);
        drain();
        // Pin3 (driven, DIR=1) falling event racing a W1C of the same bit
        gpio_port_in = 8'h08;
        repeat (LAT + 3) @(negedge clk);
        push("rise3_ignored", SRC_RD, 32'h10, 0);
        drain();
        gpio_port_in = 8'h00;
        repeat (LAT) @(negedge clk);
        wr(32'h10, 32'h08);
        push("w1c_race", SRC_RD, 32'h10, 32'h08);
        push("irq_masked", SRC_IRQ, 0, 0);
        drain();
        wr(32'h10, 32'h08);
        push("w1c_pin3", SRC_RD, 32'h10, 0);
        drain();
        // EDGE_SEL written in the cycle its old value judges a pin2 rising event
        gpio_port_in = 8'h04;
        repeat (LAT) @(negedge clk);
        wr(32'h14, 32'h05);
        @(negedge clk);
        push("edgesel_old", SRC_RD, 32'h10, 0);
        push("edgesel_rb", SRC_RD, 32'h14, 32'h05);
        drain();
        // Reset with pins high, overriding a same-cycle write
        gpio_port_in = 8'hFF;
        reset = 1'b1; Address = 32'h00; WriteData = 32'h55; MemWrite = 1'b1; Select = 1'b1;
        @(negedge clk);
        MemWrite = 1'b0; Select = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        wr(32'h14, 32'hFF);
        repeat (LAT - 2) @(negedge clk);
        push("rst_wr_override", SRC_RD, 32'h00, 0);
        push("din_early", SRC_RD, 32'h04, 0);
        push("rst_dir2", SRC_DIR, 0, 0);
        drain();
        @(negedge clk);
        push("din_sync", SRC_RD, 32'h04, 32'hFF);
        drain();
        repeat (6) @(negedge clk);
        push("arm_suppress", SRC_RD, 32'h10, 0);
        push("edgesel_ff", SRC_RD, 32'h14, 32'hFF);
        drain();
`ifdef GPIO_DEBOUNCE_EN
        gpio_port_in = 8'h00;
        repeat (LAT + 3) @(negedge clk);
        wr(32'h10, 32'hFF);
        gpio_port_in = 8'h02;
        repeat (D - 2) @(negedge clk);
        gpio_port_in = 8'h00;
        repeat (LAT + 3) @(negedge clk);
        push("db_short_din", SRC_RD, 32'h04, 0);
        push("db_short_stat", SRC_RD, 32'h10, 0);
        drain();
        gpio_port_in = 8'h02;
        repeat (LAT - 1) @(negedge clk);
        push("db_long_early", SRC_RD, 32'h04, 0);
        drain();
        @(negedge clk);
        push("db_long_din", SRC_RD, 32'h04, 32'h02);
        drain();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
